alu_exec_wb: RTL and testbench

//  Execute/write-back stage for the 8-bit, 4-register datapath. Drives sr/dr into
//  reg_group, captures its s/d read ports, and computes an ALU op (single-cycle, or an
//  8-cycle shift-add MUL). Returns the result on reg_group's i/we write port and keeps
//  a Z/C/N flag register. Runs on posedge clk; reg_group commits on the following negedge.

---
 rtl/alu_exec_wb.sv | 104 ++++++++++
 tb/tb_alu_exec_wb.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_exec_wb.sv
// alu_exec_wb: execute/write-back stage; single-cycle ALU ops or 8-step shift-add MUL,
// result returned on the reg_group write port with a {Z,C,N} flag register.
module alu_exec_wb #(
  parameter int WIDTH   = 8,
  parameter int RADDR_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [RADDR_W-1:0] sr_in,
  input  logic [RADDR_W-1:0] dr_in,
  input  logic [WIDTH-1:0]   s,
  input  logic [WIDTH-1:0]   d,
  output logic [RADDR_W-1:0] sr,
  output logic [RADDR_W-1:0] dr,
  output logic [WIDTH-1:0]   i,
  output logic               we,
  output logic               busy,
  output logic               done,
  output logic [2:0]         flags
);
  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, i_q, i_d, r;
  logic [3:0]           op_q, op_d;
  logic [RADDR_W-1:0]   sr_q, sr_d, dr_q, dr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [2:0]           flags_q, flags_d;
  logic [WIDTH:0]       alu;
  logic                 lat, mul_fin, upd, c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sr_q    <= '0;
      dr_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      i_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sr_q    <= sr_d;
      dr_q    <= dr_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      i_q     <= i_d;
      flags_q <= flags_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? (op == 4'd9 ? MUL : EXEC) : IDLE) :
              state_q == EXEC ? WB :
              state_q == MUL  ? (cnt_q == 8'd7 ? WB : MUL) : IDLE;
  end
  always_comb begin
    alu = {1'b0, b_q};
    case (op_q)
      4'd1:        alu = {1'b0, a_q} + {1'b0, b_q};
      4'd2, 4'd10: alu = {1'b0, a_q} - {1'b0, b_q};
      4'd3:        alu = {1'b0, a_q & b_q};
      4'd4:        alu = {1'b0, a_q | b_q};
      4'd5:        alu = {1'b0, a_q ^ b_q};
      4'd6:        alu = {1'b0, ~b_q};
      4'd7:        alu = {a_q, 1'b0};
      4'd8:        alu = {a_q[0], 1'b0, a_q[WIDTH-1:1]};
      default:     ;
    endcase
  end
  always_comb begin
    lat     = state_q == IDLE && start;
    a_d     = lat ? d : a_q;
    b_d     = lat ? s : b_q;
    op_d    = lat ? op : op_q;
    sr_d    = lat ? sr_in : sr_q;
    dr_d    = lat ? dr_in : dr_q;
    cnt_d   = state_q == MUL ? cnt_q + 8'd1 : 8'd0;
    // one partial product per cycle: bit cnt of B selects A shifted by cnt
    p_d     = lat ? '0 :
              state_q == MUL ? p_q + (b_q[cnt_q[2:0]] ? {{WIDTH{1'b0}}, a_q} << cnt_q[2:0] : '0) : p_q;
    mul_fin = state_q == MUL && cnt_q == 8'd7;
    upd     = (state_q == EXEC && op_q <= 4'd10) || mul_fin;
    r       = mul_fin ? p_d[WIDTH-1:0] : alu[WIDTH-1:0];
    c       = mul_fin ? |p_d[2*WIDTH-1:WIDTH] : alu[WIDTH];
    flags_d = upd ? {r == '0, c, r[WIDTH-1]} : flags_q;
    i_d     = upd && op_q != 4'd10 ? r : i_q;
  end
  always_comb begin
    sr    = state_q == IDLE ? sr_in : sr_q;
    dr    = state_q == IDLE ? dr_in : dr_q;
    we    = state_q == WB && op_q <= 4'd9;
    done  = state_q == WB;
    busy  = state_q != IDLE;
    i     = i_q;
    flags = flags_q;
  end
endmodule

// File: tb/tb_alu_exec_wb.sv
// tb_alu_exec_wb: directed and random checks of alu_exec_wb against an arithmetic model,
// with a small register file standing in for reg_group.
module tb_alu_exec_wb;
  logic       clk = 0, rst_n = 0, start = 0;
  logic [3:0] op = 0;
  logic [1:0] sr_in = 0, dr_in = 0, sr, dr;
  logic [7:0] s, d, i;
  logic       we, busy, done;
  logic [2:0] flags;
  logic [7:0] regs [4];
  logic [7:0] i_seen;
  logic [2:0] flags_seen, exp_flags = 0;
  int         n_cmp = 0, n_err = 0, we_cnt = 0;

  alu_exec_wb dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sr_in(sr_in), .dr_in(dr_in),
    .s(s), .d(d), .sr(sr), .dr(dr), .i(i), .we(we), .busy(busy), .done(done), .flags(flags)
  );

  always #5 clk = ~clk;
  assign s = regs[sr];
  assign d = regs[dr];
  always @(negedge clk) if (we) we_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int o, input int a, input int b,
                                output logic [7:0] r, output logic c);
    int t;
    t = b;
    c = 0;
    case (o)
      1:     begin t = a + b; c = t > 255; end
      2, 10: begin t = a - b; c = a < b; end
      3:     t = a & b;
      4:     t = a | b;
      5:     t = a ^ b;
      6:     t = 255 - b;
      7:     begin t = a * 2; c = a >= 128; end
      8:     begin t = a / 2; c = (a % 2) == 1; end
      9:     begin t = a * b; c = t > 255; end
      default: ;
    endcase
    r = t[7:0];
  endfunction

  task automatic init_regs();
    regs[0] = 8'h00; regs[1] = 8'hAA; regs[2] = 8'h00; regs[3] = 8'h07;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [1:0] dv, input logic [1:0] sv, input bit spam);
    logic [7:0] r;
    logic       c, wr;
    int         cyc, w0;
    @(negedge clk);
    model(int'(o), int'(regs[dv]), int'(regs[sv]), r, c);
    wr = o <= 4'd9;
    if (o <= 4'd10) exp_flags = {r == 8'h00, c, r[7]};
    start = 1; op = o; dr_in = dv; sr_in = sv;
    #1;
    chk("sr_pass", 16'(sr), 16'(sv));
    chk("dr_pass", 16'(dr), 16'(dv));
    w0 = we_cnt;
    @(posedge clk);
    #1 start = spam; op = 4'd0; cyc = 0;
    while (!done && cyc < 20) begin
      if (spam) begin sr_in = 2'($urandom); dr_in = 2'($urandom); end
      chk("busy_exec", 16'(busy), 16'd1);
      chk("sr_hold", 16'(sr), 16'(sv));
      @(posedge clk);
      #1 cyc++;
    end
    chk("latency", 16'(cyc), o == 4'd9 ? 16'd8 : 16'd1);
    chk("done_wb", 16'(done), 16'd1);
    chk("we_wb", 16'(we), 16'(wr));
    if (wr) chk("i_wb", 16'(i), 16'(r));
    chk("flags_wb", 16'(flags), 16'(exp_flags));
    i_seen = i;
    flags_seen = flags;
    @(negedge clk);
    if (we) regs[dv] = i;
    @(posedge clk);
    #1 start = 0;
    chk("done_after", 16'(done), 16'd0);
    chk("busy_after", 16'(busy), 16'd0);
    chk("we_pulses", 16'(we_cnt - w0), 16'(wr));
  endtask

  initial begin
    int w0;
    init_regs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_we", 16'(we), 16'd0);
    chk("rst_i", 16'(i), 16'd0);
    chk("rst_flags", 16'(flags), 16'd0);
    @(negedge clk) rst_n = 1;
    init_regs();
    run_op(4'd1, 2'd1, 2'd3, 0);
    chk("t1_i", 16'(i_seen), 16'hB1);
    chk("t1_flags", 16'(flags_seen), 16'b001);
    init_regs();
    run_op(4'd2, 2'd3, 2'd1, 0);
    chk("t2_i", 16'(i_seen), 16'h5D);
    chk("t2_flags", 16'(flags_seen), 16'b010);
    init_regs();
    run_op(4'd9, 2'd1, 2'd3, 0);
    chk("t3_i", 16'(i_seen), 16'hA6);
    chk("t3_flags", 16'(flags_seen), 16'b011);
    init_regs();
    run_op(4'd10, 2'd0, 2'd2, 0);
    chk("t4_flags", 16'(flags_seen), 16'b100);
    init_regs();
    run_op(4'd1, 2'd1, 2'd3, 1);
    chk("t5_r1", 16'(regs[1]), 16'hB1);
    init_regs();
    @(negedge clk);
    start = 1; op = 4'd9; dr_in = 2'd1; sr_in = 2'd3;
    @(posedge clk);
    #1 start = 0;
    w0 = we_cnt;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_busy", 16'(busy), 16'd0);
    chk("t6_flags", 16'(flags), 16'd0);
    chk("t6_we", 16'(we), 16'd0);
    chk("t6_done", 16'(done), 16'd0);
    exp_flags = 0;
    @(negedge clk) rst_n = 1;
    repeat (12) @(posedge clk);
    #1;
    chk("t6_no_write", 16'(we_cnt - w0), 16'd0);
    chk("t6_idle", 16'(busy), 16'd0);
    run_op(4'd1, 2'd1, 2'd3, 0);
    chk("t6_next_i", 16'(i_seen), 16'hB1);
    for (int k = 0; k < 4; k++) regs[k] = 8'($urandom);
    for (int n = 0; n < 40; n++)
      run_op(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), n % 5 == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
